// File: rtl/aes_key_expand_if.sv
// Key-load and round-key streaming channels of the AES-128 key expander.
// The slave side is the expander; the master side supplies keys and consumes round keys.
interface aes_key_expand_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_last, rk_valid
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_last, rk_valid
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one 128-bit key register, four S-box lookups,
// round constant advanced by xtime on every accepted round key.
//
// state | meaning
// IDLE  | waiting for a cipher key, key_ready high
// EMIT  | presenting rk_out for round rk_round, rk_valid high
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input logic             clk,
  input logic             rst,
  aes_key_expand_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic         rk_xfer;

  // Entry 0 sits in the most significant byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  always_comb begin
    t  = {sbox(bus.rk_out[23:16]), sbox(bus.rk_out[15:8]),
          sbox(bus.rk_out[7:0]),   sbox(bus.rk_out[31:24])} ^ {rcon, 24'h0};
    n0 = bus.rk_out[127:96] ^ t;
    n1 = bus.rk_out[95:64]  ^ n0;
    n2 = bus.rk_out[63:32]  ^ n1;
    n3 = bus.rk_out[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  assign rk_xfer = bus.rk_valid && bus.rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rcon          <= 8'h01;
      bus.key_ready <= 1'b1;
      bus.rk_out    <= '0;
      bus.rk_round  <= '0;
      bus.rk_last   <= 1'b0;
      bus.rk_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid && bus.key_ready) begin
            state         <= EMIT;
            rcon          <= 8'h01;
            bus.key_ready <= 1'b0;
            bus.rk_out    <= bus.key_in;
            bus.rk_round  <= '0;
            bus.rk_last   <= 1'b0;
            bus.rk_valid  <= 1'b1;
          end
        end
        EMIT: begin
          if (rk_xfer) begin
            if (bus.rk_round == LAST_ROUND) begin
              // rk_out and rk_round keep the final key for inspection.
              state         <= IDLE;
              bus.key_ready <= 1'b1;
              bus.rk_last   <= 1'b0;
              bus.rk_valid  <= 1'b0;
            end else begin
              bus.rk_out   <= next_key;
              bus.rk_round <= 4'(bus.rk_round + 4'd1);
              bus.rk_last  <= (4'(bus.rk_round + 4'd1) == LAST_ROUND);
              rcon         <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 key schedules, backpressure,
// busy-key rejection, mid-run reset and a 3-round instance.
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_if bus_a ();
  aes_key_expand_if bus_b ();

  aes_key_expand #(.NUM_ROUNDS(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  aes_key_expand #(.NUM_ROUNDS(3))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] got_rk   [0:15];
  logic [3:0]   got_rnd  [0:15];
  logic         got_last [0:15];
  int           n_xfer;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send_key_a(input logic [127:0] k);
    int w;
    w = 0;
    @(negedge clk);
    bus_a.rk_ready  = 1'b0;
    bus_a.key_in    = k;
    bus_a.key_valid = 1'b1;
    while (!bus_a.key_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("key_accept_wait", 128'(w < 50), 128'd1);
    @(negedge clk);
    bus_a.key_valid = 1'b0;
    chk("rk0_valid_next_cycle", 128'(bus_a.rk_valid), 128'd1);
  endtask

  // Consumes round keys from bus_a; optionally stalls at random and pokes a
  // second key while busy at round poke_round.
  task automatic collect_a(input bit stall, input int poke_round, input logic [127:0] poke_key);
    int           cyc;
    bit           done, have_prev, rdy;
    logic [127:0] prev_out;
    logic [3:0]   prev_rnd;
    cyc = 0; done = 0; have_prev = 0; n_xfer = 0;
    prev_out = '0; prev_rnd = '0;
    while (!done && cyc < 300) begin
      if (have_prev) begin
        chk("stall_rk_out", bus_a.rk_out, prev_out);
        chk("stall_rk_round", 128'(bus_a.rk_round), 128'(prev_rnd));
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_a.rk_ready  = rdy;
      bus_a.key_in    = poke_key;
      bus_a.key_valid = (poke_round >= 0) && bus_a.rk_valid && (int'(bus_a.rk_round) == poke_round);
      have_prev = bus_a.rk_valid && !rdy;
      prev_out  = bus_a.rk_out;
      prev_rnd  = bus_a.rk_round;
      if (bus_a.rk_valid && rdy) begin
        got_rk[n_xfer]   = bus_a.rk_out;
        got_rnd[n_xfer]  = bus_a.rk_round;
        got_last[n_xfer] = bus_a.rk_last;
        n_xfer++;
        if (bus_a.rk_last || n_xfer == 16) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus_a.key_valid = 1'b0;
    bus_a.rk_ready  = 1'b0;
    chk("schedule_done", 128'(done), 128'd1);
    chk("xfer_count", 128'(n_xfer), 128'd11);
    chk("key_ready_after", 128'(bus_a.key_ready), 128'd1);
    chk("rk_valid_after", 128'(bus_a.rk_valid), 128'd0);
  endtask

  task automatic check_fips_seq(input string tag);
    for (int i = 0; i < 11; i++) begin
      if (i < n_xfer) begin
        chk($sformatf("%s_rk%0d", tag, i), got_rk[i], fips_rk[i]);
        chk($sformatf("%s_round%0d", tag, i), 128'(got_rnd[i]), 128'(i));
        chk($sformatf("%s_last%0d", tag, i), 128'(got_last[i]), 128'(i == 10));
      end
    end
  endtask

  initial begin
    int w, nb;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    bus_a.key_in = '0; bus_a.key_valid = 1'b0; bus_a.rk_ready = 1'b0;
    bus_b.key_in = '0; bus_b.key_valid = 1'b0; bus_b.rk_ready = 1'b0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rk_valid", 128'(bus_a.rk_valid), 128'd0);
    chk("rst_rk_out", bus_a.rk_out, 128'd0);
    chk("rst_rk_round", 128'(bus_a.rk_round), 128'd0);
    chk("rst_rk_last", 128'(bus_a.rk_last), 128'd0);
    chk("rst_key_ready", 128'(bus_a.key_ready), 128'd1);

    // FIPS key, consumer always ready
    send_key_a(FIPS_KEY);
    collect_a(1'b0, -1, '0);
    check_fips_seq("full");

    // Same key under random backpressure
    send_key_a(FIPS_KEY);
    collect_a(1'b1, -1, '0);
    check_fips_seq("bp");

    // Second key offered while busy at round 4 must be ignored
    send_key_a(FIPS_KEY);
    collect_a(1'b0, 4, SEQ_KEY);
    check_fips_seq("busy");

    // Then accepted once idle
    send_key_a(SEQ_KEY);
    collect_a(1'b0, -1, '0);
    chk("seq_rk0", got_rk[0], SEQ_KEY);
    chk("seq_rk1", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("seq_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("seq_last10", 128'(got_last[10]), 128'd1);

    // Reset while presenting round 5
    send_key_a(FIPS_KEY);
    bus_a.rk_ready = 1'b1;
    w = 0;
    while (!(bus_a.rk_valid && bus_a.rk_round == 4'd5) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reach_round5", 128'(w < 50), 128'd1);
    chk("round5_key", bus_a.rk_out, fips_rk[5]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_a.rk_ready = 1'b0;
    chk("midrst_rk_valid", 128'(bus_a.rk_valid), 128'd0);
    chk("midrst_rk_out", bus_a.rk_out, 128'd0);
    chk("midrst_key_ready", 128'(bus_a.key_ready), 128'd1);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", 128'(bus_a.rk_valid), 128'd0);
    send_key_a(FIPS_KEY);
    collect_a(1'b0, -1, '0);
    check_fips_seq("restart");

    // Three-round instance
    @(negedge clk);
    bus_b.key_in    = FIPS_KEY;
    bus_b.key_valid = 1'b1;
    chk("b_key_ready", 128'(bus_b.key_ready), 128'd1);
    @(negedge clk);
    bus_b.key_valid = 1'b0;
    bus_b.rk_ready  = 1'b1;
    nb = 0;
    w  = 0;
    while (w < 20) begin
      if (bus_b.rk_valid) begin
        if (nb < 4) begin
          chk($sformatf("b_rk%0d", nb), bus_b.rk_out, fips_rk[nb]);
          chk($sformatf("b_round%0d", nb), 128'(bus_b.rk_round), 128'(nb));
          chk($sformatf("b_last%0d", nb), 128'(bus_b.rk_last), 128'(nb == 3));
        end
        nb++;
      end
      @(negedge clk);
      w++;
    end
    bus_b.rk_ready = 1'b0;
    chk("b_xfer_count", 128'(nb), 128'd4);
    chk("b_key_ready_after", 128'(bus_b.key_ready), 128'd1);
    chk("b_rk_valid_after", 128'(bus_b.rk_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-schedule generator that sits directly upstream of encryptRound and feeds its key input.
- Accepts a 128-bit cipher key over a valid/ready handshake.
- Streams round keys 0..NUM_ROUNDS, one per accepted transfer, with the round index attached.
- Uses a single registered 128-bit key state, four S-box lookups and on-the-fly Rcon generation. There is no stored key table.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted. Legal range is 1..10; 10 is standard AES-128.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_in  input  128  cipher key; byte 0 = key_in[127:120], w0 = key_in[127:96].
- key_valid  input  1  key_in is valid.
- key_ready  output  1  block idle; key transfer occurs when key_valid && key_ready.
- rk_out  output  128  current round key, same byte order as key_in.
- rk_round  output  4  round index of rk_out, 0..NUM_ROUNDS.
- rk_last  output  1  rk_round == NUM_ROUNDS while rk_valid.
- rk_valid  output  1  rk_out is valid.
- rk_ready  input  1  consumer accepts rk_out; transfer occurs when rk_valid && rk_ready.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; rk_out=0, rk_round=0, rk_valid=0, rk_last=0, rcon=8'h01. key_ready=1 from the first cycle after reset.
- Reset mid-expansion aborts immediately. No further rk_valid until a new key is accepted.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On a key transfer: rk_out<=key_in, rk_round<=0, rcon<=8'h01, next state EMIT.
- EMIT:
  - key_ready=0, rk_valid=1.
  - Without a transfer, rk_out, rk_round and rk_last hold stable (backpressure).
  - Transfer with rk_round<NUM_ROUNDS: rk_out<=next_key(rk_out, rcon), rk_round<=rk_round+1, rcon<=xtime(rcon). Stay in EMIT.
  - Transfer with rk_round==NUM_ROUNDS: next state IDLE. rk_out holds its last value; rk_valid=0.
- next_key, with w0..w3 the words of rk_out (w0 most significant):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - RotWord(w) = {w[23:0], w[31:24]}
  - SubWord applies the AES S-box per byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; result {n0,n1,n2,n3}.
- xtime:
  - rcon = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Gives 01,02,04,08,10,20,40,80,1b,36.
- Combinational rules:
  - The S-box path is combinational between state and next-state registers.
  - No combinational path from key_valid to key_ready, or from rk_ready to rk_valid.
- Latency and throughput:
  - Round key 0 is valid in the cycle after key acceptance.
  - With rk_ready held high, round k is presented k cycles later.
  - A full schedule occupies NUM_ROUNDS+1 cycles.
  - key_ready rises the cycle after the final transfer, so there is one bubble between keys.
- key_valid asserted while not IDLE is ignored. key_in is sampled only on a transfer.
- rk_round never exceeds NUM_ROUNDS and never wraps.

Test Plan:
- Reset then idle: hold rst 2 cycles -> rk_valid=0, rk_out=0, rk_round=0, key_ready=1 the cycle after rst drops.
- FIPS-197 A.1 key, rk_ready=1: drive key 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 0 key equals the input key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
  - Exactly 11 transfers occur, then key_ready=1.
- Backpressure: same key, rk_ready toggled pseudo-randomly -> identical 11-key sequence; rk_out and rk_round stable on every stalled cycle.
- Busy ignore: pulse key_valid with key 000102030405060708090a0b0c0d0e0f at round 4 -> no transfer, sequence unchanged. Drive it after the last transfer -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-operation: assert rst at round 5 -> next cycle rk_valid=0, rk_out=0, key_ready=1. The next key restarts at round 0 with rcon=01.
- NUM_ROUNDS=3 instance: FIPS key -> 4 transfers; rk_last is set on round 3 only; state returns to IDLE.
